// File: rtl/sub_mod_seq.sv
// Limb-serial modular subtractor: R = (A - B) mod M, one LIMB per cycle.
// A subtract pass produces A - B; a borrow out of the top limb triggers an add-back pass of M.
module sub_mod_seq #(
    parameter int WIDTH = 256,
    parameter int LIMB  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] opM,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int NLIMB = WIDTH / LIMB;
    localparam int IDXW  = (NLIMB > 1) ? $clog2(NLIMB) : 1;

    typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, m_q, r_q, r_nxt, out_q;
    logic [IDXW-1:0]  idx;
    logic             c;
    logic             last;
    logic [LIMB-1:0]  a_limb, b_limb, m_limb, r_limb;
    logic [LIMB:0]    sum;

    // NOTE: clocked state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt = state;
        r_nxt     = r_q;
        sum       = '0;
        a_limb    = a_q[int'(idx)*LIMB +: LIMB];
        b_limb    = b_q[int'(idx)*LIMB +: LIMB];
        m_limb    = m_q[int'(idx)*LIMB +: LIMB];
        r_limb    = r_q[int'(idx)*LIMB +: LIMB];
        last      = (idx == IDXW'(NLIMB - 1));
        case (state)
            IDLE: if (in_valid) state_nxt = SUB;
            SUB: begin
                // Bit LIMB of the 65-bit difference is the borrow out of this limb.
                sum = {1'b0, a_limb} - {1'b0, b_limb} - {{LIMB{1'b0}}, c};
                r_nxt[int'(idx)*LIMB +: LIMB] = sum[LIMB-1:0];
                if (last) state_nxt = sum[LIMB] ? CORR : DONE;
            end
            CORR: begin
                sum = {1'b0, r_limb} + {1'b0, m_limb} + {{LIMB{1'b0}}, c};
                r_nxt[int'(idx)*LIMB +: LIMB] = sum[LIMB-1:0];
                if (last) state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= '0;
            c     <= 1'b0;
            out_q <= '0;
        end else begin
            case (state)
                SUB, CORR: begin
                    if (last) begin
                        idx <= '0;
                        c   <= 1'b0;
                        if (state_nxt == DONE) out_q <= r_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                        c   <= sum[LIMB];
                    end
                end
                default: begin
                    idx <= '0;
                    c   <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: operand/work registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && in_valid) begin
            a_q <= opA;
            b_q <= opB;
            m_q <= opM;
        end else if (state == SUB || state == CORR) begin
            r_q <= r_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_q;
endmodule

// File: tb/tb_sub_mod_seq.sv
// Self-checking bench for sub_mod_seq: directed vector table, backpressure and
// mid-operation reset sequences, then randomized operations against a wide-arithmetic model.
module tb_sub_mod_seq;
    localparam int W = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] opA, opB, opM;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    sub_mod_seq #(.WIDTH(W), .LIMB(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .opM       (opM),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] m;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-width difference, plus the modulus whenever the minuend is smaller.
    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
        logic [W-1:0] d;
        d = a - b;
        if (a < b) d = d + m;
        return d;
    endfunction

    function automatic logic [W-1:0] rand256();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Issue one operation from IDLE, optionally stall the consumer and wiggle in_valid.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] m, input int hold, input bit noise,
                          input int exp_lat, input logic [W-1:0] exp_res);
        logic [W-1:0] res;
        int           lat;
        opA = a; opB = b; opM = m;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        opA = ~a; opB = a; opM = ~m;
        in_valid = noise;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, " latency"}, W'(lat), W'(exp_lat));
        if (lat < 0) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            return;
        end
        res = out_data;
        check({tag, " result"}, res, exp_res);
        check({tag, " in_ready in DONE"}, W'(in_ready), W'(0));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check({tag, " hold"}, W'({out_valid, in_ready, out_data == res}), W'(3'b101));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, " release"}, W'({out_valid, in_ready}), W'(2'b01));
    endtask

    logic [W-1:0] m_p = 256'hBFD25E8CD0364141;
    logic [W-1:0] two64  = 256'h1 << 64;
    logic [W-1:0] two255 = 256'h1 << 255;
    vec_t vecs[$];

    initial begin
        vecs.push_back('{256'h7C2FB9D7C87A1845, 256'h0471BAA664531D1A, m_p, 256'h77BDFF316426FB2B, 4});
        vecs.push_back('{256'h0471BAA664531D1A, 256'h77BDFF316426FB2B, m_p, 256'h4C861A01D0626330, 8});
        vecs.push_back('{two64, 256'h1, two255, 256'hFFFFFFFFFFFFFFFF, 4});
        vecs.push_back('{256'h1, 256'h2, two255, two255 - 256'h1, 8});
        vecs.push_back('{256'h1234, 256'h1234, m_p, 256'h0, 4});
        vecs.push_back('{256'hABCDEF, 256'h0, m_p, 256'hABCDEF, 4});
        vecs.push_back('{256'd10, 256'd3, 256'd5, 256'd7, 4});
        vecs.push_back('{256'd3, 256'd10, 256'd0, ~256'd6, 8});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opA = '0; opB = '0; opM = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset state", W'({in_ready, out_valid}), W'(2'b10));
        check("reset out_data", out_data, '0);

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].m, 0, 1'b0,
                   vecs[i].lat, vecs[i].exp);

        // Consumer stall of 5 cycles with in_valid pulsed throughout.
        run_op("backpressure", vecs[0].a, vecs[0].b, m_p, 5, 1'b1, 4, vecs[0].exp);

        // Reset during the second SUB cycle of a wrapping operation.
        opA = vecs[1].a; opB = vecs[1].b; opM = m_p;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midreset state", W'({in_ready, out_valid}), W'(2'b10));
        check("midreset out_data", out_data, '0);
        repeat (10) begin
            @(posedge clk); #1;
            check("midreset no result", W'(out_valid), W'(0));
        end
        run_op("after reset", vecs[0].a, vecs[0].b, m_p, 0, 1'b0, 4, 256'h77BDFF316426FB2B);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b, m;
            m = rand256();
            if (m == '0) m = 256'h1;
            a = rand256();
            b = rand256();
            if (i % 2 == 0) begin
                a = a % m;
                b = b % m;
            end
            if (i % 7 == 0) b = a;
            run_op($sformatf("rand%0d", i), a, b, m, int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), (a < b) ? 8 : 4, model(a, b, m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
